// File: rtl/branch_flush_ctrl_pkg.sv
// branch_flush_ctrl_pkg
// Shared types and constants for the branch/jump flush controller.
//   state_e     : controller states (RUN, SQUASH, HALT)
//   FetchLatMax : largest supported wrong-path fetch depth
//   CntW        : width of the squash down-counter
//   PerfW       : width of each performance counter
package branch_flush_ctrl_pkg;

    localparam int unsigned FetchLatMax = 7;
    localparam int unsigned CntW        = 3;
    localparam int unsigned PerfW       = 32;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StSquash = 2'd1,
        StHalt   = 2'd2
    } state_e;

endpackage

// File: rtl/branch_flush_ctrl_if.sv
// branch_flush_ctrl_if
// Bundles the hazard/branch inputs and the pipeline control outputs of
// branch_flush_ctrl.
//   master : datapath side, drives hazard/branch inputs, receives controls
//   slave  : controller side
// Inputs : branch_ex, pc_src, jump_ex, load_use, mem_wait, halt_req, resume
// Outputs: pc_we, pc_sel, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
//          fetch_squash, halted, perf_branches, perf_taken, perf_bubbles
interface branch_flush_ctrl_if;
    import branch_flush_ctrl_pkg::*;

    logic             branch_ex;
    logic             pc_src;
    logic             jump_ex;
    logic             load_use;
    logic             mem_wait;
    logic             halt_req;
    logic             resume;

    logic             pc_we;
    logic             pc_sel;
    logic             ifid_we;
    logic             idex_we;
    logic             exmem_we;
    logic             ifid_flush;
    logic             idex_flush;
    logic             fetch_squash;
    logic             halted;
    logic [PerfW-1:0] perf_branches;
    logic [PerfW-1:0] perf_taken;
    logic [PerfW-1:0] perf_bubbles;

    modport master (
        output branch_ex, pc_src, jump_ex, load_use, mem_wait, halt_req, resume,
        input  pc_we, pc_sel, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
        input  fetch_squash, halted, perf_branches, perf_taken, perf_bubbles
    );

    modport slave (
        input  branch_ex, pc_src, jump_ex, load_use, mem_wait, halt_req, resume,
        output pc_we, pc_sel, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
        output fetch_squash, halted, perf_branches, perf_taken, perf_bubbles
    );

endinterface

// File: rtl/branch_flush_ctrl_perf_counters.sv
// branch_flush_ctrl_perf_counters
// Three free-running 32-bit event counters that wrap modulo 2^32.
//   clk, rst_n     : core clock, asynchronous active-low reset
//   inc_branch     : count one branch/jump seen in EX
//   inc_taken      : count one applied redirect
//   inc_bubble     : count one flush or load-use stall cycle
//   perf_branches, perf_taken, perf_bubbles : counter values
// Freezing (mem_wait, HALT) is handled by the caller gating the inc inputs.
module branch_flush_ctrl_perf_counters
    import branch_flush_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_branch,
    input  logic             inc_taken,
    input  logic             inc_bubble,
    output logic [PerfW-1:0] perf_branches,
    output logic [PerfW-1:0] perf_taken,
    output logic [PerfW-1:0] perf_bubbles
);

    logic [PerfW-1:0] branches_q, taken_q, bubbles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branches_q <= '0;
            taken_q    <= '0;
            bubbles_q  <= '0;
        end else begin
            if (inc_branch) branches_q <= branches_q + PerfW'(1);
            if (inc_taken)  taken_q    <= taken_q + PerfW'(1);
            if (inc_bubble) bubbles_q  <= bubbles_q + PerfW'(1);
        end
    end

    assign perf_branches = branches_q;
    assign perf_taken    = taken_q;
    assign perf_bubbles  = bubbles_q;

endmodule

// File: rtl/branch_flush_ctrl.sv
// branch_flush_ctrl
// Single owner of stall and flush decisions for the 5-stage pipeline:
// applies branch/jump redirects, squashes FETCH_LAT wrong-path fetches,
// stalls on load-use, freezes on mem_wait and parks the core in HALT.
//   FETCH_LAT : wrong-path fetches in flight after a redirect (0..7)
//   clk, rst_n: core clock, asynchronous active-low reset
//   bus       : branch_flush_ctrl_if.slave (hazard inputs, pipeline controls,
//               performance counters)
// Build option: define BRANCH_PERF_EN to instantiate the performance counters;
// otherwise the perf outputs are tied to zero and no counter flops exist.
module branch_flush_ctrl
    import branch_flush_ctrl_pkg::*;
#(
    parameter int unsigned FETCH_LAT = 1
) (
    input logic             clk,
    input logic             rst_n,
    branch_flush_ctrl_if.slave bus
);

    localparam logic [CntW-1:0] CntLoad =
        (FETCH_LAT > FetchLatMax) ? CntW'(FetchLatMax) : CntW'(FETCH_LAT);
    localparam bit SquashEn = (FETCH_LAT > 0);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            redirect;

    logic pc_we, pc_sel, ifid_we, idex_we, exmem_we;
    logic ifid_flush, idex_flush, fetch_squash, halted;

    assign redirect = (bus.branch_ex & bus.pc_src) | bus.jump_ex;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: mem_wait > halt_req > redirect > load_use
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.mem_wait) begin
            unique case (state_q)
                StRun: begin
                    if (bus.halt_req) begin
                        state_d = StHalt;
                    end else if (redirect && SquashEn) begin
                        state_d = StSquash;
                        cnt_d   = CntLoad;
                    end
                end
                StSquash: begin
                    if (bus.halt_req) begin
                        state_d = StHalt;
                        cnt_d   = '0;
                    end else if (redirect) begin
                        cnt_d = CntLoad;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                        if (cnt_q == CntW'(1)) state_d = StRun;
                    end
                end
                StHalt: begin
                    if (bus.resume) state_d = StRun;
                end
                default: begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Mealy outputs; everything is forced low while reset is asserted
    always_comb begin
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        ifid_we      = 1'b0;
        idex_we      = 1'b0;
        exmem_we     = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        fetch_squash = 1'b0;
        halted       = rst_n && (state_q == StHalt);
        if (rst_n && !bus.mem_wait && !bus.halt_req) begin
            unique case (state_q)
                StRun: begin
                    if (redirect) begin
                        {pc_we, pc_sel, ifid_we, idex_we, exmem_we} = 5'b11111;
                        {ifid_flush, idex_flush}                     = 2'b11;
                    end else if (bus.load_use) begin
                        // Hold PC and IF/ID, bubble into ID/EX
                        {idex_we, exmem_we, idex_flush} = 3'b111;
                    end else begin
                        {pc_we, ifid_we, idex_we, exmem_we} = 4'b1111;
                    end
                end
                StSquash: begin
                    // The fetch returning now is wrong-path either way
                    {pc_we, ifid_we, idex_we, exmem_we} = 4'b1111;
                    {ifid_flush, fetch_squash}          = 2'b11;
                    if (redirect) {pc_sel, idex_flush} = 2'b11;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_we        = pc_we;
    assign bus.pc_sel       = pc_sel;
    assign bus.ifid_we      = ifid_we;
    assign bus.idex_we      = idex_we;
    assign bus.exmem_we     = exmem_we;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_flush   = idex_flush;
    assign bus.fetch_squash = fetch_squash;
    assign bus.halted       = halted;

`ifdef BRANCH_PERF_EN
    logic active;
    assign active = rst_n && !bus.mem_wait && (state_q != StHalt);

    branch_flush_ctrl_perf_counters u_perf (
        .clk           (clk),
        .rst_n         (rst_n),
        .inc_branch    (active && (bus.branch_ex || bus.jump_ex)),
        .inc_taken     (active && !bus.halt_req && redirect),
        .inc_bubble    (ifid_flush || idex_flush),
        .perf_branches (bus.perf_branches),
        .perf_taken    (bus.perf_taken),
        .perf_bubbles  (bus.perf_bubbles)
    );
`else
    assign bus.perf_branches = '0;
    assign bus.perf_taken    = '0;
    assign bus.perf_bubbles  = '0;
`endif

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// tb_branch_flush_ctrl
// Directed bench for branch_flush_ctrl with FETCH_LAT = 2. Each cycle's
// expected control vector is queued when the inputs are driven and checked
// at the following falling edge.
module tb_branch_flush_ctrl;

    localparam int unsigned FetchLat = 2;

    // Input vector: {branch_ex, pc_src, jump_ex, load_use, mem_wait, halt_req, resume}
    localparam logic [6:0] I_IDLE     = 7'b000_0000;
    localparam logic [6:0] I_BR_T     = 7'b110_0000;
    localparam logic [6:0] I_BR_NT    = 7'b100_0000;
    localparam logic [6:0] I_JMP      = 7'b001_0000;
    localparam logic [6:0] I_LU       = 7'b000_1000;
    localparam logic [6:0] I_BR_T_MW  = 7'b110_0100;
    localparam logic [6:0] I_HALT_JMP = 7'b001_0010;
    localparam logic [6:0] I_RESUME   = 7'b000_0001;

    // Output vector: {pc_we, pc_sel, ifid_we, idex_we, exmem_we,
    //                 ifid_flush, idex_flush, fetch_squash, halted}
    localparam logic [8:0] O_ZERO   = 9'b0_0_000_00_0_0;
    localparam logic [8:0] O_IDLE   = 9'b1_0_111_00_0_0;
    localparam logic [8:0] O_REDIR  = 9'b1_1_111_11_0_0;
    localparam logic [8:0] O_SQ     = 9'b1_0_111_10_1_0;
    localparam logic [8:0] O_LU     = 9'b0_0_011_01_0_0;
    localparam logic [8:0] O_HALTED = 9'b0_0_000_00_0_1;

`ifdef BRANCH_PERF_EN
    localparam bit PerfOn = 1'b1;
`else
    localparam bit PerfOn = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic [8:0] exp;
    } sb_item_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    sb_item_t sb[$];

    branch_flush_ctrl_if bus ();

    branch_flush_ctrl #(
        .FETCH_LAT (FetchLat)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            sb_item_t it;
            logic [8:0] obs;
            it  = sb.pop_front();
            obs = {bus.pc_we, bus.pc_sel, bus.ifid_we, bus.idex_we, bus.exmem_we,
                   bus.ifid_flush, bus.idex_flush, bus.fetch_squash, bus.halted};
            check(it.tag, 32'(obs), 32'(it.exp));
        end
    end

    task automatic drive(input string tag, input logic rst, input logic [6:0] in,
                         input logic [8:0] exp);
        sb_item_t it;
        @(posedge clk);
        #1;
        rst_n = rst;
        {bus.branch_ex, bus.pc_src, bus.jump_ex, bus.load_use,
         bus.mem_wait, bus.halt_req, bus.resume} = in;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic check_perf(input string tag, input int br, input int tk, input int bb);
        @(negedge clk);
        #1;
        check({tag, "_branches"}, bus.perf_branches, PerfOn ? 32'(br) : 32'd0);
        check({tag, "_taken"},    bus.perf_taken,    PerfOn ? 32'(tk) : 32'd0);
        check({tag, "_bubbles"},  bus.perf_bubbles,  PerfOn ? 32'(bb) : 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        {bus.branch_ex, bus.pc_src, bus.jump_ex, bus.load_use,
         bus.mem_wait, bus.halt_req, bus.resume} = I_IDLE;

        drive("reset", 1'b0, I_IDLE, O_ZERO);
        drive("reset_hold", 1'b0, I_IDLE, O_ZERO);
        for (int i = 0; i < 5; i++) drive("idle", 1'b1, I_IDLE, O_IDLE);
        check_perf("perf_reset", 0, 0, 0);

        // Taken branch: redirect, two squash cycles, back to RUN
        drive("br_taken", 1'b1, I_BR_T, O_REDIR);
        drive("squash1", 1'b1, I_IDLE, O_SQ);
        drive("squash2", 1'b1, I_IDLE, O_SQ);
        drive("run_after_sq", 1'b1, I_IDLE, O_IDLE);
        check_perf("perf_taken_br", 1, 1, 3);

        // Not-taken branch
        drive("br_not_taken", 1'b1, I_BR_NT, O_IDLE);
        drive("idle_nt", 1'b1, I_IDLE, O_IDLE);
        check_perf("perf_nt_br", 2, 1, 3);

        // Two-cycle load-use stall
        drive("load_use1", 1'b1, I_LU, O_LU);
        drive("load_use2", 1'b1, I_LU, O_LU);
        drive("lu_done", 1'b1, I_IDLE, O_IDLE);
        check_perf("perf_lu", 2, 1, 5);

        // Redirect held by mem_wait for 3 cycles, then applied
        for (int i = 0; i < 3; i++) drive("mw_freeze", 1'b1, I_BR_T_MW, O_ZERO);
        check_perf("perf_frozen", 2, 1, 5);
        drive("mw_apply", 1'b1, I_BR_T, O_REDIR);
        drive("mw_squash1", 1'b1, I_IDLE, O_SQ);
        drive("mw_squash2", 1'b1, I_IDLE, O_SQ);
        drive("mw_run", 1'b1, I_IDLE, O_IDLE);
        check_perf("perf_mw", 3, 2, 8);

        // halt_req with coincident jump: jump discarded
        drive("halt_req", 1'b1, I_HALT_JMP, O_ZERO);
        drive("halted1", 1'b1, I_IDLE, O_HALTED);
        drive("halted2", 1'b1, I_IDLE, O_HALTED);
        drive("resume", 1'b1, I_RESUME, O_HALTED);
        drive("run_after_halt", 1'b1, I_IDLE, O_IDLE);
        check_perf("perf_halt", 4, 2, 8);

        // Reset while in SQUASH with cnt=1
        drive("jump", 1'b1, I_JMP, O_REDIR);
        drive("sq_cnt2", 1'b1, I_IDLE, O_SQ);
        drive("rst_mid_sq", 1'b0, I_IDLE, O_ZERO);
        drive("rst_mid_hold", 1'b0, I_IDLE, O_ZERO);
        drive("post_rst", 1'b1, I_IDLE, O_IDLE);
        drive("post_rst2", 1'b1, I_IDLE, O_IDLE);
        check_perf("perf_post_rst", 0, 0, 0);

        for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
